// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag read/write bit, line geometry and responder FSM states.
// Pure declarations, no logic; imported by the responder and its storage.
// Ports: none.
package sysbus_pkg;

    // Bit of the request tag that selects read (1) or write (0).
    localparam int   TAG_RW        = 12;
    localparam logic SYSBUS_READ   = 1'b1;
    localparam logic SYSBUS_WRITE  = 1'b0;

    // A line is 8 beats of 64 bits; byte address bits below the line are ignored.
    localparam int   BEATS         = 8;
    localparam int   LINE_OFF_BITS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/sysbus_mem_array.sv
// Word-organised backing store for the Sysbus memory responder.
// Ports: combinational bus read (rd_*), one write port shared by bus (wr_*) and backdoor (bd_*),
// backdoor read registered (bd_rdata valid one cycle after bd_addr). Contents are never reset.
module sysbus_mem_array #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [DATA_W-1:0] bd_wdata,
    output logic [DATA_W-1:0] bd_rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] bd_rdata_d;
    logic [DATA_W-1:0] bd_rdata_q;

    // Single write port: a backdoor write claims it, so on a same-word
    // collision with a bus write the backdoor value is what lands.
    always_comb begin
        we    = wr_en | bd_we;
        waddr = bd_we ? bd_addr  : wr_addr;
        wdata = bd_we ? bd_wdata : wr_data;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data = mem[rd_addr];

    always_comb begin
        bd_rdata_d = mem[bd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bd_rdata_q <= '0;
        end else begin
            bd_rdata_q <= bd_rdata_d;
        end
    end

    assign bd_rdata = bd_rdata_q;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory endpoint: accepts address beat (+8 write beats) and returns 8 tagged read beats.
// Ports: bus_req* request side (reqack combinational), bus_resp* response side held until respack,
// bd_* bench backdoor into the store, oob one-cycle pulse for an address past the last line.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int MEM_LINES      = 256,
    parameter int READ_LATENCY   = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0]            bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
    output logic                                 bus_reqack,
    output logic                                 bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]            bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]             bus_resptag,
    input  logic                                 bus_respack,
    input  logic                                 bd_we,
    input  logic [$clog2(MEM_LINES*BEATS)-1:0]   bd_addr,
    input  logic [BUS_DATA_WIDTH-1:0]            bd_wdata,
    output logic [BUS_DATA_WIDTH-1:0]            bd_rdata,
    output logic                                 oob
);

    localparam int LINE_W  = $clog2(MEM_LINES);
    localparam int BEAT_W  = $clog2(BEATS);
    localparam int ADDR_W  = LINE_W + BEAT_W;
    localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(READ_LATENCY - 1);

    state_t                     state_q, state_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [LAT_W-1:0]           lat_q, lat_d;
    logic [LINE_W-1:0]          line_q, line_d;
    logic                       oor_q, oor_d;
    logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                       oob_q, oob_d;

    logic                       req_xfer;
    logic [LINE_W-1:0]          req_line;
    logic                       req_oor;
    logic                       mem_we;
    logic [ADDR_W-1:0]          word_addr;
    logic [BUS_DATA_WIDTH-1:0]  mem_rdata;
    logic                       unused_req_offset;

    // Line index comes from the bits just above the byte offset; any set bit
    // above that means the line lies beyond the store.
    assign req_line          = bus_req[LINE_OFF_BITS +: LINE_W];
    assign req_oor           = |bus_req[BUS_DATA_WIDTH-1:LINE_OFF_BITS+LINE_W];
    assign unused_req_offset = ^bus_req[LINE_OFF_BITS-1:0];

    // Held low during reset so the initiator never sees a phantom accept.
    assign bus_reqack = reset & bus_reqcyc & ((state_q == IDLE) | (state_q == WDATA));
    assign req_xfer   = bus_reqack;

    assign word_addr = {line_q, beat_q};

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        line_d  = line_q;
        oor_d   = oor_q;
        tag_d   = tag_q;
        oob_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_xfer) begin
                    line_d = req_line;
                    oor_d  = req_oor;
                    tag_d  = bus_reqtag;
                    oob_d  = req_oor;
                    beat_d = '0;
                    if (bus_reqtag[TAG_RW] == SYSBUS_READ) begin
                        state_d = WAIT;
                        lat_d   = LAT_INIT;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (req_xfer) begin
                    // Out-of-range lines still consume all beats but never touch the store.
                    mem_we = ~oor_q;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RESP: begin
                if (bus_respack) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            line_q  <= '0;
            oor_q   <= 1'b0;
            tag_q   <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            line_q  <= line_d;
            oor_q   <= oor_d;
            tag_q   <= tag_d;
            oob_q   <= oob_d;
        end
    end

    sysbus_mem_array #(
        .DATA_W (BUS_DATA_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (reset),
        .rd_addr  (word_addr),
        .rd_data  (mem_rdata),
        .wr_en    (mem_we),
        .wr_addr  (word_addr),
        .wr_data  (bus_req),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata)
    );

    // Read data is live from the store so a backdoor write to the word on
    // the bus shows up the following cycle.
    assign bus_respcyc = (state_q == RESP);
    assign bus_resp    = (bus_respcyc && !oor_q) ? mem_rdata : '0;
    assign bus_resptag = tag_q;
    assign oob         = oob_q;

endmodule
